pc_sequencer: RTL

Multi-cycle program-counter sequencer for the CPU core. It owns the architectural PC register, fetches each instruction from instruction memory over a req/ack handshake, and presents the instruction to the datapath. It then commits the next-PC value that the next-PC logic computes when the datapath signals completion. It also provides halt, a fetch watchdog, misalignment fault detection and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_sequencer_fetch_watchdog.sv | 32 +++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-core types and constants used by the PC sequencer and its watchdog.
package cpu_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_HALTED,
      ST_FAULT
   } pcseq_state_t;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
   localparam logic [1:0]  INS_ALIGN_MASK   = 2'b11;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] & INS_ALIGN_MASK) != 2'b00;
   endfunction
endpackage

// File: rtl/pc_sequencer_fetch_watchdog.sv
// Counts consecutive un-acked fetch cycles; o_expired flags the cycle whose count reaches TIMEOUT.
// TIMEOUT of 0 disables it; the count clears whenever the fetch is acked or not in progress.
module fetch_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Expiry is flagged one count early so the sequencer leaves FETCH on the edge the count hits TIMEOUT.
   generate
      if (TIMEOUT == 0) begin : g_off
         assign o_expired = 1'b0;
      end else begin : g_on
         assign o_expired = i_en && (r_cnt == W'(TIMEOUT - 1));
      end
   endgenerate
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch over req/ack, hold instruction until ex_done, commit next PC.
// ack -> ins_valid next cycle; ex_done -> next imem_req next cycle; all outputs registered.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
   parameter int          TIMEOUT  = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_ins,
   output logic [31:0] o_ins_addr,
   output logic        o_ins_valid,
   input  logic        i_ex_done,
   input  logic [31:0] i_next_ins_addr,
   input  logic        i_halt,
   output logic        o_fault,
   output logic [31:0] o_retire_cnt
);
   pcseq_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_ins;
   logic         r_req;
   logic         r_ins_valid;
   logic         r_fault;
   logic [31:0]  r_retire_cnt;

   logic w_wd_en;
   logic w_wd_clr;
   logic w_wd_expired;

   assign w_wd_en  = (r_state == ST_FETCH) && !i_imem_ack;
   assign w_wd_clr = (r_state != ST_FETCH) || i_imem_ack;

   fetch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_ins        <= '0;
         r_req        <= 1'b0;
         r_ins_valid  <= 1'b0;
         r_fault      <= 1'b0;
         r_retire_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_halt) begin
                  r_state <= ST_HALTED;
               end else if (is_misaligned(r_pc)) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_state <= ST_FETCH;
                  r_req   <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (i_imem_ack) begin
                  r_ins       <= i_imem_rdata;
                  r_req       <= 1'b0;
                  r_ins_valid <= 1'b1;
                  r_state     <= ST_EXEC;
               end else if (w_wd_expired) begin
                  r_req   <= 1'b0;
                  r_fault <= 1'b1;
                  r_state <= ST_FAULT;
               end
            end
            ST_EXEC: begin
               if (i_ex_done) begin
                  // PC is committed even when misaligned so the bad target stays visible.
                  r_pc         <= i_next_ins_addr;
                  r_retire_cnt <= r_retire_cnt + 32'd1;
                  r_ins_valid  <= 1'b0;
                  if (is_misaligned(i_next_ins_addr)) begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end else if (i_halt) begin
                     r_state <= ST_HALTED;
                  end else begin
                     r_state <= ST_FETCH;
                     r_req   <= 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               if (!i_halt) begin
                  if (is_misaligned(r_pc)) begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= ST_FETCH;
                     r_req   <= 1'b1;
                  end
               end
            end
            ST_FAULT: begin
               r_fault <= 1'b1;
            end
            default: begin
               r_state <= ST_FAULT;
               r_fault <= 1'b1;
            end
         endcase
      end
   end

   assign o_imem_req   = r_req;
   assign o_imem_addr  = r_pc;
   assign o_ins        = r_ins;
   assign o_ins_addr   = r_pc;
   assign o_ins_valid  = r_ins_valid;
   assign o_fault      = r_fault;
   assign o_retire_cnt = r_retire_cnt;
endmodule
